// File: rtl/aes_core_arbiter_if.sv
// Requester, result and shared-core signal bundle for aes_core_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface aes_core_arbiter_if;
  logic         req0;
  logic         req1;
  logic [127:0] key0;
  logic [127:0] key1;
  logic [127:0] pt0;
  logic [127:0] pt1;
  logic         gnt0;
  logic         gnt1;
  logic [127:0] ct;
  logic         ct_valid;
  logic         ct_id;
  logic         ct_ack;
  logic         core_start;
  logic [127:0] core_key;
  logic [127:0] core_state;
  logic [127:0] core_out;
  logic         core_done;
  logic         busy;
  logic         err_timeout;
  logic [31:0]  enc_count;

  modport slave (
    input  req0, req1, key0, key1, pt0, pt1, ct_ack, core_out, core_done,
    output gnt0, gnt1, ct, ct_valid, ct_id, core_start, core_key, core_state,
           busy, err_timeout, enc_count
  );

  modport master (
    output req0, req1, key0, key1, pt0, pt1, ct_ack, core_out, core_done,
    input  gnt0, gnt1, ct, ct_valid, ct_id, core_start, core_key, core_state,
           busy, err_timeout, enc_count
  );
endinterface

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES-128 core between two requesters,
// with a bounded wait for the core and a held result until acknowledged.
module aes_core_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 31
) (
  input logic                clk,
  input logic                rst,
  aes_core_arbiter_if.slave  bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e         state_q;
  logic           gnt0_q;
  logic           gnt1_q;
  logic           core_start_q;
  logic [127:0]   key_q;
  logic [127:0]   pt_q;
  logic           idx_q;
  logic           last_q;
  logic [TW-1:0]  timer_q;
  logic [127:0]   ct_q;
  logic           ct_valid_q;
  logic           ct_id_q;
  logic [31:0]    enc_count_q;
  logic           err_timeout_q;
  logic           pick1_d;

  // Requester 1 wins when it is alone, or when both ask and 0 was served last.
  assign pick1_d = bus.req1 && (!bus.req0 || !last_q);

  assign bus.gnt0        = gnt0_q;
  assign bus.gnt1        = gnt1_q;
  assign bus.core_start  = core_start_q;
  assign bus.core_key    = key_q;
  assign bus.core_state  = pt_q;
  assign bus.ct          = ct_q;
  assign bus.ct_valid    = ct_valid_q;
  assign bus.ct_id       = ct_id_q;
  assign bus.enc_count   = enc_count_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.busy        = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      core_start_q  <= 1'b0;
      key_q         <= '0;
      pt_q          <= '0;
      idx_q         <= 1'b0;
      last_q        <= 1'b1;
      timer_q       <= '0;
      ct_q          <= '0;
      ct_valid_q    <= 1'b0;
      ct_id_q       <= 1'b0;
      enc_count_q   <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      core_start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            idx_q   <= pick1_d;
            key_q   <= pick1_d ? bus.key1 : bus.key0;
            pt_q    <= pick1_d ? bus.pt1 : bus.pt0;
            gnt0_q  <= !pick1_d;
            gnt1_q  <= pick1_d;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          core_start_q <= 1'b1;
          timer_q      <= '0;
          state_q      <= WAIT;
        end
        WAIT: begin
          // A completion in the final allowed cycle still counts as success.
          if (bus.core_done) begin
            ct_q        <= bus.core_out;
            ct_valid_q  <= 1'b1;
            ct_id_q     <= idx_q;
            enc_count_q <= enc_count_q + 32'd1;
            state_q     <= RESP;
          end else if (timer_q == TIMER_LAST) begin
            timer_q       <= timer_q + TW'(1);
            err_timeout_q <= 1'b1;
            last_q        <= idx_q;
            state_q       <= IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        RESP: begin
          if (bus.ct_ack) begin
            ct_valid_q <= 1'b0;
            last_q     <= idx_q;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_core_arbiter.md
AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 31: max cycles waited for core_done after core_start.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0, req1  input  1  encryption request from requester 0 / 1 (level, held until grant).
REQ-005 SHALL have ports key0, key1  input  128  cipher key per requester.
REQ-006 SHALL have ports pt0, pt1  input  128  plaintext per requester.
REQ-007 SHALL have ports gnt0, gnt1  output  1  one-cycle pulse: request accepted, operands captured.
REQ-008 SHALL have port ct  output  128  ciphertext result.
REQ-009 SHALL have port ct_valid  output  1  ct/ct_id valid; held until ct_ack.
REQ-010 SHALL have port ct_id  output  1  requester index owning ct.
REQ-011 SHALL have port ct_ack  input  1  result consumed.
REQ-012 SHALL have ports core_start  output  1, core_key  output  128, core_state  output  128: shared AES-128 core issue.
REQ-013 SHALL have ports core_out  input  128, core_done  input  1: core result and one-cycle completion strobe.
REQ-014 SHALL have ports busy  output  1, err_timeout  output  1, enc_count  output  32.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; busy = (state != IDLE).
REQ-016 IDLE: if req0 or req1, SHALL select a requester, register its key/pt and index, pulse matching gnt for one cycle, go ISSUE; otherwise stay.
REQ-017 Selection SHALL be round-robin: requester not served last wins when both request; single requester always wins.
REQ-018 ISSUE: core_start SHALL be 1 for exactly one cycle, timer cleared, go WAIT.
REQ-019 core_key/core_state SHALL present registered operands from ISSUE through WAIT, stable.
REQ-020 WAIT: on core_done SHALL capture core_out into ct, set ct_valid=1, ct_id=index, increment enc_count, go RESP.
REQ-021 WAIT: timer SHALL increment per cycle without core_done; at timer==TIMEOUT_CYC SHALL set err_timeout=1, not assert ct_valid, mark index as served, go IDLE.
REQ-022 core_done arriving in the same cycle the timer reaches TIMEOUT_CYC SHALL be treated as success (no error).
REQ-023 RESP: ct, ct_id, ct_valid SHALL hold until ct_ack=1; then ct_valid=0, index marked served, go IDLE.
REQ-024 core_done outside WAIT SHALL be ignored; ct_ack outside RESP SHALL be ignored.
REQ-025 Request change after grant SHALL not affect the in-flight operation; gnt never asserted outside IDLE->ISSUE transition.
REQ-026 enc_count SHALL wrap 0xFFFFFFFF -> 0; err_timeout SHALL be sticky until reset.
REQ-027 Minimum latency req-to-ct_valid SHALL be 3 cycles plus core latency (grant, issue, done-capture).

Reset
REQ-028 rst=0 SHALL immediately force IDLE, gnt0=gnt1=0, core_start=0, ct_valid=0, ct=0, ct_id=0, core_key=core_state=0, enc_count=0, err_timeout=0, timer=0.
REQ-029 After reset, round-robin SHALL favour requester 0 on the first simultaneous request.
REQ-030 Reset asserted mid-operation SHALL abort it with no result and no enc_count update; late core_done after release SHALL be ignored.

Verification
REQ-031 req0=1 only, key0=000102..0f, pt0=00112233..ff, core returns 69c4e0d8..c55a after 10 cycles -> gnt0 pulse, core_start once, ct_valid with ct=69c4..c55a, ct_id=0, enc_count=1.
REQ-032 req0=req1=1 held continuously after reset -> grant order 0,1,0,1; each ct_id matches granted index.
REQ-033 core_done withheld -> core_start once, err_timeout=1 exactly TIMEOUT_CYC cycles into WAIT, ct_valid stays 0, FSM returns IDLE and serves other requester next.
REQ-034 ct_ack held 0 for 20 cycles in RESP -> ct/ct_valid stable, no new gnt; ct_ack=1 -> ct_valid=0 next cycle.
REQ-035 rst=0 pulsed during WAIT, then core_done -> all outputs reset values, done ignored, enc_count=0.
REQ-036 enc_count forced path: 2^32 completions (or preload via backdoor 0xFFFFFFFF) -> next completion yields 0.
